// File: rtl/intersection_traffic_model_pkg.sv
// -----------------------------------------------------------------------------
// intersection_traffic_model_pkg
// Shared types and constants for the intersection model: the light colour
// enum used by the traffic light controller, lane index constants, the lane
// FSM state type and the lane-pair conflict matrix.
// Optional feature macro used elsewhere: INTERSECTION_MODEL_STATS_EN.
// -----------------------------------------------------------------------------
package intersection_traffic_model_pkg;

  typedef enum logic [1:0] {
    red    = 2'd0,
    yellow = 2'd1,
    green  = 2'd2
  } colors;

  localparam int LANE_E_STR  = 0;
  localparam int LANE_W_STR  = 1;
  localparam int LANE_E_LEFT = 2;
  localparam int LANE_W_LEFT = 3;
  localparam int LANE_NS     = 4;
  localparam int NUM_LANES   = 5;

  // Row i has bit j set when lanes i and j may never be shown together.
  localparam logic [NUM_LANES-1:0][NUM_LANES-1:0] CONFLICT_MATRIX = {
    5'b01111,  // ns      : every other lane
    5'b10001,  // w_left  : ns, e_str
    5'b10010,  // e_left  : ns, w_str
    5'b10100,  // w_str   : ns, e_left
    5'b11000   // e_str   : ns, w_left
  };

  typedef enum logic [1:0] {
    LANE_STOP = 2'd0,
    LANE_WARM = 2'd1,
    LANE_FLOW = 2'd2
  } lane_state_t;

  function automatic logic light_shown(colors c);
    return c != red;
  endfunction

  function automatic logic light_go(colors c);
    return c == green;
  endfunction

endpackage

// File: rtl/intersection_traffic_model_if.sv
// -----------------------------------------------------------------------------
// intersection_traffic_model_if
// Bundle between the light controller side (master) and the intersection
// model (slave).
//   master drives : five lights, arrive[4:0]
//   slave drives  : five sensors, depart, q_count, overflow, conflict,
//                   conflict_lanes, and wait_cycles when
//                   INTERSECTION_MODEL_STATS_EN is defined
// Lane index order for all vectors: {ns, w_left, e_left, w_str, e_str}.
// -----------------------------------------------------------------------------
interface intersection_traffic_model_if #(
  parameter int QDEPTH = 15
);
  import intersection_traffic_model_pkg::*;

  localparam int QW = $clog2(QDEPTH + 1);

  colors                            e_str_light;
  colors                            w_str_light;
  colors                            e_left_light;
  colors                            w_left_light;
  colors                            ns_light;
  logic [NUM_LANES-1:0]             arrive;

  logic                             e_str_sensor;
  logic                             w_str_sensor;
  logic                             e_left_sensor;
  logic                             w_left_sensor;
  logic                             ns_sensor;
  logic [NUM_LANES-1:0]             depart;
  logic [NUM_LANES-1:0][QW-1:0]     q_count;
  logic [NUM_LANES-1:0]             overflow;
  logic                             conflict;
  logic [NUM_LANES-1:0]             conflict_lanes;
`ifdef INTERSECTION_MODEL_STATS_EN
  logic [NUM_LANES-1:0][15:0]       wait_cycles;
`endif

  modport master (
    output e_str_light, w_str_light, e_left_light, w_left_light, ns_light,
    output arrive,
    input  e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor,
    input  depart, q_count, overflow, conflict, conflict_lanes
`ifdef INTERSECTION_MODEL_STATS_EN
    , input wait_cycles
`endif
  );

  modport slave (
    input  e_str_light, w_str_light, e_left_light, w_left_light, ns_light,
    input  arrive,
    output e_str_sensor, w_str_sensor, e_left_sensor, w_left_sensor, ns_sensor,
    output depart, q_count, overflow, conflict, conflict_lanes
`ifdef INTERSECTION_MODEL_STATS_EN
    , output wait_cycles
`endif
  );

endinterface

// File: rtl/intersection_traffic_model_lane_queue.sv
// -----------------------------------------------------------------------------
// intersection_traffic_model_lane_queue
// One lane of the intersection: vehicle queue, paced departure FSM and sticky
// overflow flag. Optional wait-cycle statistic under INTERSECTION_MODEL_STATS_EN.
//   clk, reset   : clock, synchronous active-high reset
//   light        : this lane's light colour
//   arrive       : one-cycle arrival pulse
//   depart       : one-cycle departure pulse (combinational)
//   q            : registered queue occupancy
//   overflow     : sticky, an arrival was dropped at full queue
//   wait_cycles  : (stats only) cycles with q > 0 while not green, saturating
//
// state     | meaning
// ----------+-----------------------------------------------------------
// LANE_STOP | light not green; gcnt held at START_DELAY
// LANE_WARM | green, start-up delay running down in gcnt
// LANE_FLOW | green, departs when gcnt == 0 and q > 0; gap reloads gcnt
// -----------------------------------------------------------------------------
module intersection_traffic_model_lane_queue
  import intersection_traffic_model_pkg::*;
#(
  parameter int QDEPTH      = 15,
  parameter int START_DELAY = 1,
  parameter int DEPART_GAP  = 2,
  localparam int QW         = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  colors         light,
  input  logic          arrive,
  output logic          depart,
  output logic [QW-1:0] q,
  output logic          overflow
`ifdef INTERSECTION_MODEL_STATS_EN
  , output logic [15:0] wait_cycles
`endif
);

  localparam int GMAX = (START_DELAY > DEPART_GAP - 1) ? START_DELAY : DEPART_GAP - 1;
  localparam int GW   = (GMAX < 1) ? 1 : $clog2(GMAX + 1);

  localparam logic [GW-1:0] GCNT_START = GW'(START_DELAY);
  localparam logic [GW-1:0] GCNT_GAP   = GW'(DEPART_GAP - 1);
  localparam logic [GW-1:0] GCNT_ONE   = GW'(1);
  localparam logic [QW-1:0] Q_FULL     = QW'(QDEPTH);

  lane_state_t   state;
  logic [GW-1:0] gcnt;
  logic          go;
  logic          full;
  logic          accept;
  logic          can_go_now;

  assign go   = light_go(light);
  assign full = (q == Q_FULL);

  // With no start-up delay the very first green cycle may already depart,
  // which the STOP state has to allow since FLOW is only reached next cycle.
  assign can_go_now = (state == LANE_FLOW) ||
                      (state == LANE_STOP && START_DELAY == 0);

  assign depart = go && (gcnt == '0) && (q != '0) && can_go_now;

  // A departure in the same cycle frees the slot, so a full queue still accepts.
  assign accept = arrive && (!full || depart);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LANE_STOP;
      gcnt     <= GCNT_START;
      q        <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept && !depart)
        q <= q + QW'(1);
      else if (!accept && depart)
        q <= q - QW'(1);

      if (arrive && !accept)
        overflow <= 1'b1;

      unique case (state)
        LANE_STOP: begin
          if (!go) begin
            gcnt <= GCNT_START;
          end else if (depart) begin
            state <= LANE_FLOW;
            gcnt  <= GCNT_GAP;
          end else if (gcnt <= GCNT_ONE) begin
            state <= LANE_FLOW;
            gcnt  <= '0;
          end else begin
            state <= LANE_WARM;
            gcnt  <= gcnt - GCNT_ONE;
          end
        end
        LANE_WARM: begin
          if (!go) begin
            state <= LANE_STOP;
            gcnt  <= GCNT_START;
          end else if (gcnt <= GCNT_ONE) begin
            state <= LANE_FLOW;
            gcnt  <= '0;
          end else begin
            gcnt <= gcnt - GCNT_ONE;
          end
        end
        LANE_FLOW: begin
          if (!go) begin
            state <= LANE_STOP;
            gcnt  <= GCNT_START;
          end else if (depart) begin
            gcnt <= GCNT_GAP;
          end else if (gcnt != '0) begin
            gcnt <= gcnt - GCNT_ONE;
          end
        end
        default: begin
          state <= LANE_STOP;
          gcnt  <= GCNT_START;
        end
      endcase
    end
  end

`ifdef INTERSECTION_MODEL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)
      wait_cycles <= '0;
    else if (q != '0 && !go && wait_cycles != 16'hFFFF)
      wait_cycles <= wait_cycles + 16'd1;
  end
`endif

endmodule

// File: rtl/intersection_traffic_model.sv
// -----------------------------------------------------------------------------
// intersection_traffic_model
// Synthesizable model of the intersection behind the traffic light
// controller: five lane queues, sensor mapping and a sticky conflict monitor.
//   clk, reset : clock, synchronous active-high reset
//   bus        : intersection_traffic_model_if.slave
//                (lights/arrive in; sensors, depart, q_count, overflow,
//                 conflict, conflict_lanes out; wait_cycles when
//                 INTERSECTION_MODEL_STATS_EN is defined)
// -----------------------------------------------------------------------------
module intersection_traffic_model
  import intersection_traffic_model_pkg::*;
#(
  parameter int QDEPTH      = 15,
  parameter int START_DELAY = 1,
  parameter int DEPART_GAP  = 2,
  localparam int QW         = $clog2(QDEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  intersection_traffic_model_if.slave bus
);

  colors                        light_vec [NUM_LANES];
  logic [NUM_LANES-1:0]         shown;
  logic [NUM_LANES-1:0]         depart_v;
  logic [NUM_LANES-1:0]         overflow_v;
  logic [QW-1:0]                q_v [NUM_LANES];
  logic                         illegal;
  logic                         conflict_q;
  logic [NUM_LANES-1:0]         conflict_lanes_q;

  assign light_vec[LANE_E_STR]  = bus.e_str_light;
  assign light_vec[LANE_W_STR]  = bus.w_str_light;
  assign light_vec[LANE_E_LEFT] = bus.e_left_light;
  assign light_vec[LANE_W_LEFT] = bus.w_left_light;
  assign light_vec[LANE_NS]     = bus.ns_light;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign shown[i] = light_shown(light_vec[i]);

    intersection_traffic_model_lane_queue #(
      .QDEPTH      (QDEPTH),
      .START_DELAY (START_DELAY),
      .DEPART_GAP  (DEPART_GAP)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .light       (light_vec[i]),
      .arrive      (bus.arrive[i]),
      .depart      (depart_v[i]),
      .q           (q_v[i]),
      .overflow    (overflow_v[i])
`ifdef INTERSECTION_MODEL_STATS_EN
      , .wait_cycles (bus.wait_cycles[i])
`endif
    );

    assign bus.q_count[i] = q_v[i];
  end

  assign bus.depart   = depart_v;
  assign bus.overflow = overflow_v;

  assign bus.e_str_sensor  = (q_v[LANE_E_STR]  != '0);
  assign bus.w_str_sensor  = (q_v[LANE_W_STR]  != '0);
  assign bus.e_left_sensor = (q_v[LANE_E_LEFT] != '0);
  assign bus.w_left_sensor = (q_v[LANE_W_LEFT] != '0);
  assign bus.ns_sensor     = (q_v[LANE_NS]     != '0);

  always_comb begin
    illegal = 1'b0;
    for (int i = 0; i < NUM_LANES; i++)
      illegal = illegal | (shown[i] & |(shown & CONFLICT_MATRIX[i]));
  end

  // Only the first illegal cycle is captured so the log points at the root cause.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_q       <= 1'b0;
      conflict_lanes_q <= '0;
    end else if (illegal && !conflict_q) begin
      conflict_q       <= 1'b1;
      conflict_lanes_q <= shown;
    end
  end

  assign bus.conflict       = conflict_q;
  assign bus.conflict_lanes = conflict_lanes_q;

endmodule
